memory_stage_ctrl: RTL and testbench

//  Memory-stage controller of the pipelined MIPS core; sits between the EX/MEM latch and the MEM/WB latch.

---
 rtl/memory_stage_ctrl_if.sv | 44 ++++
 rtl/memory_stage_ctrl.sv | 153 +++++++++++++++
 tb/tb_memory_stage_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_ctrl_if.sv
// Memory-stage bus bundle: EX/MEM request side, dcache
// side, snoop input and MEM/WB latch controls.
interface memory_stage_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              ex_valid;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_datomic;
  logic [WORD_W-1:0] ex_addr;
  logic [WORD_W-1:0] ex_store;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              snoop_inv;
  logic [WORD_W-1:0] snoop_addr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic [WORD_W-1:0] dload;
  logic              mem_done;
  logic              mem_datomic;
  logic              latch_en;
  logic              mem_stall;
  logic              mem_timeout;

  modport master (
    output ex_valid, ex_MemRead, ex_MemWrite,
    output ex_datomic, ex_addr, ex_store,
    output dhit, dmemload, snoop_inv, snoop_addr,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dload, mem_done, mem_datomic,
    input  latch_en, mem_stall, mem_timeout
  );

  modport slave (
    input  ex_valid, ex_MemRead, ex_MemWrite,
    input  ex_datomic, ex_addr, ex_store,
    input  dhit, dmemload, snoop_inv, snoop_addr,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dload, mem_done, mem_datomic,
    output latch_en, mem_stall, mem_timeout
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Memory-stage controller: dcache request sequencing,
// LL/SC link register with snoop invalidation, stalls.
module memory_stage_ctrl #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input logic                CLK,
  input logic                RST,
  memory_stage_ctrl_if.slave m
);
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t            state;
  logic              op_read;
  logic              op_write;
  logic              op_atomic;
  logic [WORD_W-1:0] op_addr;
  logic [WORD_W-1:0] op_store;
  logic [WORD_W-1:0] dload_r;
  logic              link_valid;
  logic [WORD_W-1:0] link_addr;
  logic [9:0]        wait_cnt;
  logic              timeout_r;

  logic memop;
  logic is_sc;
  logic sc_fail;
  logic req_hit;
  logic snoop_kill;

  assign memop = m.ex_valid
               & (m.ex_MemRead | m.ex_MemWrite);
  assign is_sc = m.ex_MemWrite & ~m.ex_MemRead
               & m.ex_datomic;
  assign sc_fail = memop & is_sc
                 & ~(link_valid
                     & (link_addr == m.ex_addr));
  assign req_hit = (state == REQ) & m.dhit;

  // A matching snoop kills the reservation, including
  // one an LL is establishing in this very cycle.
  assign snoop_kill = m.snoop_inv & (
      (link_valid & (m.snoop_addr == link_addr))
    | (req_hit & op_read & op_atomic
       & (m.snoop_addr == op_addr)));

  // Request FSM: capture, hold until dhit, one-cycle done.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op_read   <= 1'b0;
      op_write  <= 1'b0;
      op_atomic <= 1'b0;
      op_addr   <= '0;
      op_store  <= '0;
      dload_r   <= '0;
      wait_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      unique case (state)
        REQ: begin
          if (wait_cnt == TMO) timeout_r <= 1'b1;
          if (m.dhit) begin
            state <= DONE;
            if (op_read)
              dload_r <= m.dmemload;
            else if (op_atomic)
              dload_r <= WORD_W'(1);
          end else if (wait_cnt != TMO) begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        IDLE, DONE: begin
          state <= IDLE;
          if (memop) begin
            op_read   <= m.ex_MemRead;
            op_write  <= ~m.ex_MemRead;
            op_atomic <= m.ex_datomic;
            op_addr   <= m.ex_addr;
            op_store  <= m.ex_store;
            if (sc_fail) begin
              state   <= DONE;
              dload_r <= '0;
            end else begin
              state    <= REQ;
              wait_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link register, highest-priority clear first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (snoop_kill) begin
      link_valid <= 1'b0;
    end else if (req_hit & op_write
                 & (op_atomic
                    | (op_addr == link_addr))) begin
      link_valid <= 1'b0;
    end else if (req_hit & op_read & op_atomic) begin
      link_valid <= 1'b1;
      link_addr  <= op_addr;
    end
  end

  // Outputs decoded from state; reset silences them.
  always_comb begin
    m.dmemREN     = 1'b0;
    m.dmemWEN     = 1'b0;
    m.dmemaddr    = '0;
    m.dmemstore   = '0;
    m.dload       = '0;
    m.mem_done    = 1'b0;
    m.mem_datomic = 1'b0;
    m.latch_en    = ~memop;
    m.mem_stall   = 1'b0;
    m.mem_timeout = 1'b0;
    if (!RST) begin
      m.mem_timeout = timeout_r;
      unique case (state)
        IDLE: m.mem_stall = memop;
        REQ: begin
          m.dmemREN   = op_read;
          m.dmemWEN   = op_write;
          m.dmemaddr  = op_addr;
          m.dmemstore = op_store;
          m.latch_en  = 1'b0;
          m.mem_stall = 1'b1;
        end
        DONE: begin
          m.mem_done    = 1'b1;
          m.mem_datomic = op_atomic;
          m.dload       = dload_r;
          m.latch_en    = 1'b1;
          m.mem_stall   = 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Bench for memory_stage_ctrl: scripted memory ops with
// a completion scoreboard checked on every mem_done.
module tb_memory_stage_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_stage_ctrl_if #(.WORD_W(32)) bus ();

  memory_stage_ctrl #(
    .WORD_W (32),
    .TIMEOUT(1023)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .m  (bus.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic        a;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_dload = '0;

  // Scoreboard: every completion must match the oldest
  // expected result.
  always @(negedge clk) begin
    if (bus.mem_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: done dload=%h, want none",
                 bus.dload);
      end else begin
        e = exp_q.pop_front();
        if (bus.dload !== e.d || bus.mem_datomic !== e.a) begin
          failures++;
          $display("FAIL sb_result: dload=%h at=%b, want %h %b",
                   bus.dload, bus.mem_datomic, e.d, e.a);
        end
      end
    end
  end

  task automatic clear_in();
    bus.ex_valid    = 1'b0;
    bus.ex_MemRead  = 1'b0;
    bus.ex_MemWrite = 1'b0;
    bus.ex_datomic  = 1'b0;
    bus.ex_addr     = '0;
    bus.ex_store    = '0;
    bus.dhit        = 1'b0;
    bus.dmemload    = '0;
    bus.snoop_inv   = 1'b0;
    bus.snoop_addr  = '0;
  endtask

  task automatic set_op(input logic rd, input logic wr,
                        input logic at,
                        input logic [31:0] addr,
                        input logic [31:0] st);
    bus.ex_valid    = 1'b1;
    bus.ex_MemRead  = rd;
    bus.ex_MemWrite = wr;
    bus.ex_datomic  = at;
    bus.ex_addr     = addr;
    bus.ex_store    = st;
  endtask

  // Presents one op for a cycle, answers with dhit on the
  // dly-th request cycle, and tallies what it observed.
  task automatic run_op(
    input logic rd, input logic wr, input logic at,
    input logic [31:0] addr, input logic [31:0] st,
    input int dly, input logic [31:0] rdata,
    input logic snp,
    output int n_ren, output int n_wen,
    output int n_stall, output int n_done,
    output int n_cyc,
    output logic [31:0] s_addr,
    output logic [31:0] s_store,
    output logic tmo);
    int reqc;
    n_ren = 0; n_wen = 0; n_stall = 0;
    n_done = 0; n_cyc = 0; reqc = 0;
    s_addr = '0; s_store = '0; tmo = 1'b1;
    set_op(rd, wr, at, addr, st);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_cyc++;
      if (bus.dmemREN === 1'b1) n_ren++;
      if (bus.dmemWEN === 1'b1) n_wen++;
      if (bus.mem_stall === 1'b1) n_stall++;
      if (bus.mem_done === 1'b1) n_done++;
      if (bus.dmemREN === 1'b1 || bus.dmemWEN === 1'b1) begin
        reqc++;
        s_addr  = bus.dmemaddr;
        s_store = bus.dmemstore;
        if (reqc == dly) begin
          bus.dhit     = 1'b1;
          bus.dmemload = rdata;
          if (snp) begin
            bus.snoop_inv  = 1'b1;
            bus.snoop_addr = addr;
          end
        end
      end
      @(posedge clk); #1;
      bus.ex_valid  = 1'b0;
      bus.dhit      = 1'b0;
      bus.snoop_inv = 1'b0;
      if (n_done != 0) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.dmemREN, bus.dmemWEN, bus.mem_done,
         bus.mem_datomic, bus.mem_stall,
         bus.mem_timeout, bus.latch_en} !== 7'b0000001
        || bus.dload !== 32'h0 || bus.dmemaddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outs: ren=%b stall=%b latch=%b dload=%h, want 0 0 1 0",
               bus.dmemREN, bus.mem_stall, bus.latch_en, bus.dload);
    end
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_stall !== 1'b0 || bus.latch_en !== 1'b0
        || bus.dmemREN !== 1'b0) begin
      failures++;
      $display("FAIL reset_memop: stall=%b latch=%b ren=%b, want 0 0 0",
               bus.mem_stall, bus.latch_en, bus.dmemREN);
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.dmemREN, bus.dmemWEN, bus.mem_done,
         bus.mem_datomic, bus.mem_stall,
         bus.mem_timeout, bus.latch_en} !== 7'b0000001
        || bus.dload !== 32'h0) begin
      failures++;
      $display("FAIL reset_after: ren=%b done=%b stall=%b latch=%b, want 0 0 0 1",
               bus.dmemREN, bus.mem_done, bus.mem_stall, bus.latch_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int r, w, s, d, c;
    logic [31:0] a, st;
    logic t;
    exp_q.push_back('{32'hDEADBEEF, 1'b0});
    m_dload = 32'hDEADBEEF;
    run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3,
           32'hDEADBEEF, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || r != 3 || w != 0 || s != 4 || d != 1
        || c != 5 || a !== 32'h100) begin
      failures++;
      $display("FAIL lw_timing: tmo=%b ren=%0d wen=%0d stall=%0d cyc=%0d addr=%h, want 0 3 0 4 5 100",
               t, r, w, s, c, a);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_done !== 1'b0 || bus.latch_en !== 1'b1) begin
      failures++;
      $display("FAIL lw_pulse: done=%b latch=%b, want 0 1",
               bus.mem_done, bus.latch_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ll_sc();
    int r, w, s, d, c;
    logic [31:0] a, st;
    logic t;
    exp_q.push_back('{32'hA5, 1'b1});
    run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 1,
           32'hA5, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || r != 1 || c != 3) begin
      failures++;
      $display("FAIL ll_issue: tmo=%b ren=%0d cyc=%0d, want 0 1 3",
               t, r, c);
    end
    exp_q.push_back('{32'd1, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h200, 32'd7, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 1 || st !== 32'd7 || a !== 32'h200) begin
      failures++;
      $display("FAIL sc_ok: tmo=%b wen=%0d store=%h addr=%h, want 0 1 7 200",
               t, w, st, a);
    end
    exp_q.push_back('{32'd0, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h200, 32'd9, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 0 || c != 2 || s != 1) begin
      failures++;
      $display("FAIL sc_consumed: tmo=%b wen=%0d cyc=%0d stall=%0d, want 0 0 2 1",
               t, w, c, s);
    end
    m_dload = 32'd0;
  endtask

  task automatic test_snoop();
    int r, w, s, d, c;
    logic [31:0] a, st;
    logic t;
    exp_q.push_back('{32'h5A, 1'b1});
    run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 1,
           32'h5A, 1'b0, r, w, s, d, c, a, st, t);
    bus.snoop_inv  = 1'b1;
    bus.snoop_addr = 32'h200;
    @(posedge clk); #1;
    bus.snoop_inv = 1'b0;
    exp_q.push_back('{32'd0, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h200, 32'd3, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 0 || c != 2) begin
      failures++;
      $display("FAIL snoop_sc: tmo=%b wen=%0d cyc=%0d, want 0 0 2",
               t, w, c);
    end
    m_dload = 32'd0;
  endtask

  task automatic test_sw_kill();
    int r, w, s, d, c;
    logic [31:0] a, st;
    logic t;
    exp_q.push_back('{32'h11, 1'b1});
    run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 2,
           32'h11, 1'b0, r, w, s, d, c, a, st, t);
    exp_q.push_back('{32'h11, 1'b0});
    run_op(1'b0, 1'b1, 1'b0, 32'h200, 32'h44, 2,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 2 || st !== 32'h44) begin
      failures++;
      $display("FAIL sw_issue: tmo=%b wen=%0d store=%h, want 0 2 44",
               t, w, st);
    end
    exp_q.push_back('{32'd0, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h200, 32'd5, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 0) begin
      failures++;
      $display("FAIL sw_same_sc: tmo=%b wen=%0d, want 0 0",
               t, w);
    end
    exp_q.push_back('{32'h22, 1'b1});
    run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 1,
           32'h22, 1'b0, r, w, s, d, c, a, st, t);
    exp_q.push_back('{32'h22, 1'b0});
    run_op(1'b0, 1'b1, 1'b0, 32'h204, 32'h66, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    exp_q.push_back('{32'd1, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h200, 32'd6, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 1 || a !== 32'h200) begin
      failures++;
      $display("FAIL sw_other_sc: tmo=%b wen=%0d addr=%h, want 0 1 200",
               t, w, a);
    end
    m_dload = 32'd1;
  endtask

  task automatic test_snoop_race();
    int r, w, s, d, c;
    logic [31:0] a, st;
    logic t;
    exp_q.push_back('{32'h33, 1'b1});
    run_op(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 1,
           32'h33, 1'b1, r, w, s, d, c, a, st, t);
    exp_q.push_back('{32'd0, 1'b1});
    run_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd8, 1,
           32'h0, 1'b0, r, w, s, d, c, a, st, t);
    checks++;
    if (t || w != 0 || c != 2) begin
      failures++;
      $display("FAIL snoop_race: tmo=%b wen=%0d cyc=%0d, want 0 0 2",
               t, w, c);
    end
    m_dload = 32'd0;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{32'h1111, 1'b0});
    exp_q.push_back('{32'h2222, 1'b0});
    set_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h1111;
    @(posedge clk); #1;
    bus.dhit = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_done !== 1'b1 || bus.mem_stall !== 1'b0
        || bus.latch_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: done=%b stall=%b latch=%b, want 1 0 1",
               bus.mem_done, bus.mem_stall, bus.latch_en);
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dmemREN !== 1'b1 || bus.dmemaddr !== 32'h44) begin
      failures++;
      $display("FAIL b2b_req: ren=%b addr=%h, want 1 44",
               bus.dmemREN, bus.dmemaddr);
    end
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h2222;
    @(posedge clk); #1;
    bus.dhit = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: done=%b, want 1",
               bus.mem_done);
    end
    @(posedge clk); #1;
    m_dload = 32'h2222;
  endtask

  task automatic test_timeout();
    exp_q.push_back('{32'h77, 1'b0});
    set_op(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    for (int k = 1; k <= 1025; k++) begin
      @(negedge clk);
      if (k == 1024) begin
        checks++;
        if (bus.mem_timeout !== 1'b0 || bus.dmemREN !== 1'b1) begin
          failures++;
          $display("FAIL tmo_early: tmo=%b ren=%b, want 0 1",
                   bus.mem_timeout, bus.dmemREN);
        end
      end
      if (k == 1025) begin
        checks++;
        if (bus.mem_timeout !== 1'b1 || bus.dmemREN !== 1'b1) begin
          failures++;
          $display("FAIL tmo_set: tmo=%b ren=%b, want 1 1",
                   bus.mem_timeout, bus.dmemREN);
        end
      end
      @(posedge clk); #1;
    end
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h77;
    @(posedge clk); #1;
    bus.dhit = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b1 || bus.dmemREN !== 1'b0) begin
      failures++;
      $display("FAIL tmo_sticky: tmo=%b ren=%b, want 1 0",
               bus.mem_timeout, bus.dmemREN);
    end
    @(posedge clk); #1;
    m_dload = 32'h77;
  endtask

  task automatic test_rst_mid_req();
    set_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dmemREN !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: ren=%b, want 1", bus.dmemREN);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dmemREN !== 1'b0 || bus.mem_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop: ren=%b done=%b, want 0 0",
               bus.dmemREN, bus.mem_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dmemREN !== 1'b0 || bus.mem_done !== 1'b0
        || bus.latch_en !== 1'b1 || bus.mem_timeout !== 1'b0
        || bus.mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle: ren=%b done=%b latch=%b tmo=%b stall=%b, want 0 0 1 0 0",
               bus.dmemREN, bus.mem_done, bus.latch_en,
               bus.mem_timeout, bus.mem_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.mem_done !== 1'b0 || bus.dmemREN !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet: done=%b ren=%b, want 0 0",
               bus.mem_done, bus.dmemREN);
    end
    @(posedge clk); #1;
    m_dload = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_ll_sc();
    test_snoop();
    test_sw_kill();
    test_snoop_race();
    test_back_to_back();
    test_timeout();
    test_rst_mid_req();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d, want 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
